// File: rtl/uart_cmd_ctrl.sv
// Assembles UART bytes into 3-byte commands (op, data hi, data lo) with inter-byte timeout.
// Define UART_CMD_CHKSUM_EN to require a 4th checksum byte (op+hi+lo+chk == 0 mod 256).
//
// state | meaning
// IDLE  | waiting for opcode byte
// B1    | opcode captured, waiting for data high byte
// B2    | data high captured, waiting for data low byte
// CHK   | data low captured, waiting for checksum byte (checksum build only)
module uart_cmd_ctrl #(
    parameter int TMO_CYCLES = 131072,
    parameter int TMR_W      = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        busy,
    output logic        tmo_err,
    output logic        cmd_ovr,
    output logic        chk_err
);

`ifdef UART_CMD_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, B1, B2, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, B1, B2} state_t;
`endif

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_CYCLES - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [7:0]       op_sh;
    logic [7:0]       hi_sh;
    logic [7:0]       new_lo;
    logic             complete;

    assign clr_rx_rdy = rx_rdy;
    assign busy       = (state != IDLE);

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] lo_sh;
    logic [7:0] sum;
    logic       chk_bad;
    logic       chk_err_q;

    assign chk_err = chk_err_q;

    always_comb begin
        sum      = op_sh + hi_sh + lo_sh + rx_data;
        new_lo   = lo_sh;
        complete = 1'b0;
        chk_bad  = 1'b0;
        if (state == CHK && rx_rdy) begin
            if (sum == 8'h00) complete = 1'b1;
            else              chk_bad  = 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;

    always_comb begin
        new_lo   = rx_data;
        complete = (state == B2) && rx_rdy;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            op_sh    <= 8'h00;
            hi_sh    <= 8'h00;
            cmd_op   <= 8'h00;
            cmd_data <= 16'h0000;
            cmd_rdy  <= 1'b0;
            tmo_err  <= 1'b0;
            cmd_ovr  <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            lo_sh     <= 8'h00;
            chk_err_q <= 1'b0;
`endif
        end else begin
            tmo_err <= 1'b0;
            cmd_ovr <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            chk_err_q <= 1'b0;
`endif
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;

            if (rx_rdy) begin
                timer <= '0;
                case (state)
                    IDLE: begin
                        op_sh <= rx_data;
                        state <= B1;
                    end
                    B1: begin
                        hi_sh <= rx_data;
                        state <= B2;
                    end
`ifdef UART_CMD_CHKSUM_EN
                    B2: begin
                        lo_sh <= rx_data;
                        state <= CHK;
                    end
                    CHK: begin
                        chk_err_q <= chk_bad;
                        state     <= IDLE;
                    end
`else
                    B2:      state <= IDLE;
`endif
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (timer == TMO_LAST) begin
                    // abandoned packet: drop the partial bytes, leave the last command alone
                    state   <= IDLE;
                    timer   <= '0;
                    tmo_err <= 1'b1;
                    op_sh   <= 8'h00;
                    hi_sh   <= 8'h00;
`ifdef UART_CMD_CHKSUM_EN
                    lo_sh   <= 8'h00;
`endif
                end else begin
                    timer <= timer + 1'b1;
                end
            end

            // set wins over a same-cycle clear; overrun only if the old command was still unread
            if (complete) begin
                cmd_op   <= op_sh;
                cmd_data <= {hi_sh, new_lo};
                cmd_rdy  <= 1'b1;
                cmd_ovr  <= cmd_rdy & ~clr_cmd_rdy;
            end
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Sequences the byte-level UART receiver into fixed 3-byte command packets (opcode, data high, data low) for the balance controller's command path. It consumes the receiver's rx_rdy/rx_data and issues the clr_rx_rdy acknowledge. It enforces an inter-byte timeout and presents each complete command atomically with its own ready/clear handshake.

Parameters:
TMO_CYCLES, 131072, clock cycles allowed between consecutive bytes of one packet before the packet is abandoned (≥2).
TMR_W, 17, timer width; must satisfy 2^TMR_W ≥ TMO_CYCLES.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  receiver byte-ready level
rx_data  input  8  receiver byte, valid while rx_rdy=1
clr_rx_rdy  output  1  combinational one-cycle acknowledge to receiver
cmd_op  output  8  opcode of last complete command
cmd_data  output  16  data of last complete command, {byte1, byte2}
cmd_rdy  output  1  complete command pending
clr_cmd_rdy  input  1  consumer acknowledge for cmd_rdy
busy  output  1  packet in progress (state ≠ IDLE)
tmo_err  output  1  one-cycle pulse: packet abandoned on timeout
cmd_ovr  output  1  one-cycle pulse: new command completed while cmd_rdy=1
chk_err  output  1  one-cycle pulse: checksum mismatch (0 when feature off)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. All registers use it.
- Reset values: state IDLE; cmd_op=0x00; cmd_data=0x0000; cmd_rdy=0; tmo_err=0; cmd_ovr=0; chk_err=0; timer=0; byte shadow registers=0.
- States: IDLE, B1, B2, and CHK (CHK present only with the feature). In every state, the block accepts a byte in any cycle where rx_rdy=1.
  - clr_rx_rdy = rx_rdy in every state, combinationally, for exactly that cycle.
  - The receiver clears rdy on that edge, so each byte is acknowledged exactly once.
- IDLE: on an accepted byte, capture it into the op shadow, clear the timer, and go to B1.
- B1: on an accepted byte, capture it into the hi shadow, clear the timer, and go to B2.
- B2: on an accepted byte, capture it as the lo byte and complete the packet (or go to CHK with the feature).
- Completion, same edge as the final byte:
  - cmd_op and cmd_data are loaded from the shadows together with the final byte, atomically.
  - cmd_rdy is set to 1 and the state returns to IDLE.
  - cmd_op and cmd_data change only at completion.
- Timer: increments every cycle in B1, B2 and CHK while no byte is accepted.
  - Timeout occurs when timer == TMO_CYCLES-1 and rx_rdy=0: go to IDLE, pulse tmo_err, discard the shadows, leave cmd_* and cmd_rdy untouched.
  - If rx_rdy=1 in the timeout cycle, the byte is accepted and no timeout occurs.
- cmd_rdy: set on completion, cleared by clr_cmd_rdy. Set has priority over clear in the same cycle.
- Overrun: if completion occurs while cmd_rdy=1 (and no clr_cmd_rdy that cycle), overwrite the outputs, keep cmd_rdy=1, and pulse cmd_ovr.
- Receiving continues regardless of cmd_rdy; the block never stalls the receiver.
- Reset asserted mid-packet: return to the reset values immediately; the partial packet is lost.
- All error pulses are registered and last exactly one cycle.
- busy is combinational from state.

Optional Feature:
Macro: UART_CMD_CHKSUM_EN.
- Defined:
  - After B2 the block enters CHK and waits for a 4th byte, under the same timer and acknowledge rules.
  - Valid packet: (op + hi + lo + chk) mod 256 == 0x00. Then complete as above.
  - Otherwise go to IDLE, pulse chk_err, and leave cmd_* and cmd_rdy unchanged.
- Undefined: packet is 3 bytes, there is no CHK state, and chk_err is tied to 0.

Test Plan:
- Bytes 0x05,0x12,0x34 spaced 26040 cycles apart → cmd_op=0x05, cmd_data=0x1234, cmd_rdy=1 on the 3rd byte's edge; clr_rx_rdy high for exactly 3 single cycles; busy=0 after. (Feature on: append 0xB5 for the same result.)
- 0x05,0x12 then idle for TMO_CYCLES → tmo_err one-cycle pulse, busy=0, cmd_rdy stays 0. Then 0xA0,0x00,0x01 → cmd_op=0xA0, cmd_data=0x0001.
- rx_rdy asserted in exactly the cycle timer == TMO_CYCLES-1 in B1 → byte accepted, no tmo_err, state B2.
- Command completes with cmd_rdy=1 and no clear → cmd_ovr pulse, outputs show new values. Completion coincident with clr_cmd_rdy=1 → cmd_rdy remains 1, no cmd_ovr.
- rst_n low for 1 cycle while in B2 → all outputs at reset values. Next 0x07,0xFF,0xFE yields cmd_op=0x07, cmd_data=0xFFFE.
- Feature on: 0x05,0x12,0x34,0xB4 → chk_err pulse, cmd_rdy=0, cmd_op/cmd_data unchanged from prior values.
